// File: rtl/spi_request_arbiter.sv
// -----------------------------------------------------------------------------
// spi_request_arbiter
//
// Shares one SPI serializer among NUM_REQ command sources. A round-robin
// arbiter picks a requester, latches its word onto the serializer data input
// and pulses ser_ld. The arbiter then follows the serializer's chip-select to
// decide when the frame has finished. It reports done, or err if CS never
// went low, back to the requester that owns the transfer.
//
// Ports
//   clk       clock, shared with the serializer
//   rst       synchronous reset, active-high
//   req       per-requester level request, held until ack
//   req_data  per-requester words, slice i = [i*DATA_W +: DATA_W]
//   ack       1-cycle pulse: request accepted, word latched
//   done      1-cycle pulse: transfer finished (CS rose again)
//   err       1-cycle pulse: serializer never lowered CS after the load
//   busy      high whenever the FSM is not in IDLE
//   gnt_id    index of the current or last granted requester
//   ser_data  word presented to the serializer
//   ser_ld    load strobe to the serializer
//   ser_cs    chip-select from the serializer (low = frame in progress)
// -----------------------------------------------------------------------------
module spi_request_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 32,
    parameter int LD_CYCLES     = 2,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic [DATA_W-1:0]          ser_data,
    output logic                       ser_ld,
    input  logic                       ser_cs
);

    localparam int IDW     = $clog2(NUM_REQ);
    // One counter serves the LOAD, WAIT_START and GAP phases. It must be
    // wide enough for the longest of the three.
    localparam int CNT_MAX = (LD_CYCLES > START_TIMEOUT)
                             ? ((LD_CYCLES > GAP_CYCLES) ? LD_CYCLES : GAP_CYCLES)
                             : ((START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        SHIFT,
        GAP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic [NUM_REQ-1:0]   err_reg, err_next;
    logic                 ld_reg, ld_next;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic [IDW-1:0]       gnt_reg, gnt_next;
    logic [IDW-1:0]       last_reg, last_next;

    // Unpack the flat data bus into one word per requester.
    logic [DATA_W-1:0]    req_word [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Round-robin winner: first set request scanning last+1, last+2, ...
    // The scan runs from the farthest candidate to the nearest, so the
    // nearest set request is the last one written and therefore wins.
    logic [IDW-1:0] win;
    logic           win_valid;
    logic [IDW-1:0] idx;

    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last_reg) + k) % NUM_REQ);
            if (req[idx]) begin
                win       = idx;
                win_valid = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ack_reg   <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
            ld_reg    <= 1'b0;
            data_reg  <= '0;
            gnt_reg   <= '0;
            last_reg  <= IDW'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            ld_reg    <= ld_next;
            data_reg  <= data_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = '0;
        done_next  = '0;
        err_next   = '0;
        ld_next    = 1'b0;
        data_next  = data_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;

        case (state_reg)
            IDLE: begin
                // A grant is made only while CS is high. After a reset in the
                // middle of a frame, the serializer is left to finish the
                // frame before its data register is touched again.
                if (win_valid && ser_cs) begin
                    data_next     = req_word[win];
                    ack_next[win] = 1'b1;
                    gnt_next      = win;
                    last_next     = win;
                    cnt_next      = '0;
                    state_next    = LOAD;
                end
            end

            LOAD: begin
                // The first LOAD cycle is the ack cycle, so ser_ld (registered)
                // rises one cycle after ack and stays high LD_CYCLES cycles.
                if (cnt_reg == CNT_W'(LD_CYCLES)) begin
                    cnt_next   = '0;
                    state_next = WAIT_START;
                end else begin
                    ld_next  = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            WAIT_START: begin
                if (!ser_cs) begin
                    cnt_next   = '0;
                    state_next = SHIFT;
                end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
                    err_next[gnt_reg] = 1'b1;
                    cnt_next          = '0;
                    state_next        = GAP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            SHIFT: begin
                // The serializer owns the frame length, so SHIFT has no
                // timeout of its own.
                if (ser_cs) begin
                    done_next[gnt_reg] = 1'b1;
                    cnt_next           = '0;
                    state_next         = GAP;
                end
            end

            GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ack      = ack_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign busy     = (state_reg != IDLE);
    assign gnt_id   = gnt_reg;
    assign ser_data = data_reg;
    assign ser_ld   = ld_reg;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_request_arbiter
//
// Directed bench for spi_request_arbiter. A small behavioural serializer
// captures ser_data while ser_ld is high. After ser_ld falls, it holds CS low
// for DATA_W cycles and shifts the word out MSB first into rx_word. Clearing
// model_en turns it into a serializer that never starts a frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_request_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 32;
    localparam int LD_CYCLES     = 2;
    localparam int START_TIMEOUT = 16;
    localparam int GAP_CYCLES    = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic                      busy;
    logic [1:0]                gnt_id;
    logic [DATA_W-1:0]         ser_data;
    logic                      ser_ld;
    logic                      ser_cs = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_request_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .LD_CYCLES     (LD_CYCLES),
        .START_TIMEOUT (START_TIMEOUT),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .ser_data (ser_data),
        .ser_ld   (ser_ld),
        .ser_cs   (ser_cs)
    );

    // Behavioural serializer. It is never reset, like the real serializer.
    logic              model_en  = 1'b1;
    logic              ld_d      = 1'b0;
    logic [DATA_W-1:0] shreg     = '0;
    logic [DATA_W-1:0] rx_word   = '0;
    int                bits_left = 0;

    always @(posedge clk) begin
        ld_d <= ser_ld;
        if (ser_ld === 1'b1) shreg <= ser_data;
        if (ld_d === 1'b1 && ser_ld === 1'b0 && model_en && ser_cs) begin
            ser_cs    <= 1'b0;
            bits_left <= DATA_W;
        end else if (!ser_cs) begin
            rx_word   <= {rx_word[DATA_W-2:0], shreg[DATA_W-1]};
            shreg     <= {shreg[DATA_W-2:0], 1'b0};
            bits_left <= bits_left - 1;
            if (bits_left == 1) ser_cs <= 1'b1;
        end
    end

    // Protocol watchers, checked at the end of the run.
    bit mon_en     = 1'b0;
    int ld_overlap = 0;
    int multi_hot  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ser_ld === 1'b1 && ser_cs === 1'b0) ld_overlap <= ld_overlap + 1;
            if ($countones(ack | done | err) > 1)   multi_hot  <= multi_hot + 1;
        end
    end

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_checks++; if (done !== 4'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
        n_checks++; if (err !== 4'b0)     begin n_fail++; $display("FAIL reset_err: got %b want 0000", err); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (ser_ld !== 1'b0)  begin n_fail++; $display("FAIL reset_ser_ld: got %b want 0", ser_ld); end
        n_checks++; if (gnt_id !== 2'd0)  begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        n_checks++; if (ser_data !== '0)  begin n_fail++; $display("FAIL reset_ser_data: got %h want 0", ser_data); end
        rst = 1'b0;
        mon_en = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        int k;
        int low;
        int cyc;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        n_checks++; if (ack !== 4'b0001)           begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
        n_checks++; if (ser_data !== 32'h009E6D55) begin n_fail++; $display("FAIL single_data: got %h want 009e6d55", ser_data); end
        n_checks++; if (ser_ld !== 1'b0)           begin n_fail++; $display("FAIL single_ld_early: got %b want 0", ser_ld); end
        req = 4'b0000;
        @(negedge clk);
        n_checks++; if (ser_ld !== 1'b1) begin n_fail++; $display("FAIL single_ld_c1: got %b want 1", ser_ld); end
        @(negedge clk);
        n_checks++; if (ser_ld !== 1'b1) begin n_fail++; $display("FAIL single_ld_c2: got %b want 1", ser_ld); end
        @(negedge clk);
        n_checks++; if (ser_ld !== 1'b0) begin n_fail++; $display("FAIL single_ld_c3: got %b want 0", ser_ld); end
        k = 0;
        while (ser_cs !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        low = 0;
        while (ser_cs === 1'b0 && low < 100) begin @(negedge clk); low++; end
        n_checks++; if (low != DATA_W)              begin n_fail++; $display("FAIL single_frame_len: got %0d want %0d", low, DATA_W); end
        n_checks++; if (done !== 4'b0000)           begin n_fail++; $display("FAIL single_done_early: got %b want 0000", done); end
        n_checks++; if (rx_word !== 32'h009E6D55)   begin n_fail++; $display("FAIL single_spi_bits: got %h want 009e6d55", rx_word); end
        @(negedge clk);
        n_checks++; if (done !== 4'b0001)           begin n_fail++; $display("FAIL single_done: got %b want 0001", done); end
        wait_idle(cyc);
        n_checks++; if (cyc >= 200)                 begin n_fail++; $display("FAIL single_idle: got %0d cycles want <200", cyc); end
        $display("single: req0 transfer word %h frame %0d cycles", rx_word, low);
    endtask

    task automatic test_round_robin();
        int k;
        int cyc;
        int exp_id;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % NUM_REQ;
            k = 0;
            while (ack === 4'b0 && k < 200) begin @(negedge clk); k++; end
            n_checks++; if (ack !== 4'(1 << exp_id)) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", g, ack, 4'(1 << exp_id)); end
            n_checks++; if (gnt_id !== 2'(exp_id))   begin n_fail++; $display("FAIL rr_gnt_%0d: got %0d want %0d", g, gnt_id, exp_id); end
            n_checks++; if (ser_data !== req_data[exp_id*DATA_W +: DATA_W])
                begin n_fail++; $display("FAIL rr_data_%0d: got %h want %h", g, ser_data, req_data[exp_id*DATA_W +: DATA_W]); end
            $display("rr: grant %0d to requester %0d data %h", g, gnt_id, ser_data);
            @(negedge clk);
        end
        req = 4'b0000;
        wait_idle(cyc);
        n_checks++; if (cyc >= 200)    begin n_fail++; $display("FAIL rr_idle: got %0d cycles want <200", cyc); end
        n_checks++; if (ld_overlap != 0) begin n_fail++; $display("FAIL rr_ld_overlap: got %0d want 0", ld_overlap); end
    endtask

    task automatic test_timeout();
        int k;
        int cyc;
        bit done_seen;
        model_en = 1'b0;
        req = 4'b0100;
        k = 0;
        while (ack === 4'b0 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL to_ack: got %b want 0100", ack); end
        req = 4'b0000;
        k = 0;
        while (ser_ld !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        while (ser_ld !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        done_seen = 1'b0;
        while (err === 4'b0 && k < 40) begin
            @(negedge clk);
            k++;
            if (done !== 4'b0) done_seen = 1'b1;
        end
        n_checks++; if (k != START_TIMEOUT) begin n_fail++; $display("FAIL to_delay: got %0d want %0d", k, START_TIMEOUT); end
        n_checks++; if (err !== 4'b0100)    begin n_fail++; $display("FAIL to_err: got %b want 0100", err); end
        n_checks++; if (done_seen)          begin n_fail++; $display("FAIL to_no_done: got done want none"); end
        model_en = 1'b1;
        req = 4'b0001;
        k = 0;
        while (ack === 4'b0 && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (k != GAP_CYCLES + 1) begin n_fail++; $display("FAIL to_next_grant: got %0d want %0d", k, GAP_CYCLES + 1); end
        n_checks++; if (ack !== 4'b0001)     begin n_fail++; $display("FAIL to_next_ack: got %b want 0001", ack); end
        req = 4'b0000;
        wait_idle(cyc);
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL to_idle: got %0d cycles want <200", cyc); end
        $display("timeout: err after %0d cycles, regrant checked", START_TIMEOUT);
    endtask

    task automatic test_reset_in_shift();
        int k;
        int cyc;
        bit early;
        req = 4'b0010;
        k = 0;
        while (ack === 4'b0 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rs_ack: got %b want 0010", ack); end
        req = 4'b0000;
        k = 0;
        while (ser_cs !== 1'b0 && k < 30) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({ack, done, err} !== 12'h000) begin n_fail++; $display("FAIL rs_pulses: got %h want 000", {ack, done, err}); end
        n_checks++; if (ser_ld !== 1'b0)  begin n_fail++; $display("FAIL rs_ser_ld: got %b want 0", ser_ld); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rs_busy: got %b want 0", busy); end
        n_checks++; if (gnt_id !== 2'd0)  begin n_fail++; $display("FAIL rs_gnt_id: got %0d want 0", gnt_id); end
        n_checks++; if (ser_data !== '0)  begin n_fail++; $display("FAIL rs_ser_data: got %h want 0", ser_data); end
        k = 0;
        early = 1'b0;
        while (ser_cs === 1'b0 && k < 100) begin
            if ({ack, done, err} !== 12'h000) early = 1'b1;
            @(negedge clk);
            k++;
        end
        if (ack !== 4'b0) early = 1'b1;
        n_checks++; if (early) begin n_fail++; $display("FAIL rs_hold_off: got pulse while CS low want none"); end
        @(negedge clk);
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL rs_ack_after_cs: got %b want 1000", ack); end
        req = 4'b0000;
        wait_idle(cyc);
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL rs_idle: got %0d cycles want <200", cyc); end
        $display("reset_in_shift: pending req3 granted after CS high");
    endtask

    task automatic test_withdraw();
        int k;
        int ld_hi;
        bit seen2;
        req = 4'b0010;
        k = 0;
        while (ack === 4'b0 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL wd_ack1: got %b want 0010", ack); end
        req = 4'b0100;
        seen2 = 1'b0;
        ld_hi = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack[2] === 1'b1) seen2 = 1'b1;
            if (ser_ld === 1'b1) ld_hi++;
        end
        req = 4'b0000;
        k = 0;
        while ((busy !== 1'b0 || k < 10) && k < 200) begin
            @(negedge clk);
            k++;
            if (ack[2] === 1'b1) seen2 = 1'b1;
            if (ser_ld === 1'b1) ld_hi++;
        end
        n_checks++; if (seen2)            begin n_fail++; $display("FAIL wd_no_ack2: got ack[2] want none"); end
        n_checks++; if (ld_hi != LD_CYCLES) begin n_fail++; $display("FAIL wd_one_load: got %0d ld cycles want %0d", ld_hi, LD_CYCLES); end
        n_checks++; if (gnt_id !== 2'd1)  begin n_fail++; $display("FAIL wd_gnt_id: got %0d want 1", gnt_id); end
        $display("withdraw: req2 withdrawn, no grant");
    endtask

    task automatic test_req_at_done();
        int k;
        int cyc;
        req = 4'b1000;
        k = 0;
        while (ack === 4'b0 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL rd_ack1: got %b want 1000", ack); end
        req = 4'b0000;
        k = 0;
        while (done === 4'b0 && k < 200) begin @(negedge clk); k++; end
        n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL rd_done: got %b want 1000", done); end
        req = 4'b1000;
        k = 0;
        while (ack === 4'b0 && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (k != GAP_CYCLES + 1) begin n_fail++; $display("FAIL rd_regrant_delay: got %0d want %0d", k, GAP_CYCLES + 1); end
        n_checks++; if (ack !== 4'b1000)     begin n_fail++; $display("FAIL rd_ack2: got %b want 1000", ack); end
        req = 4'b0000;
        wait_idle(cyc);
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL rd_idle: got %0d cycles want <200", cyc); end
        $display("req_at_done: regrant to 3 after %0d cycles", k);
    endtask

    task automatic test_protocol();
        n_checks++; if (ld_overlap != 0) begin n_fail++; $display("FAIL proto_ld_overlap: got %0d want 0", ld_overlap); end
        n_checks++; if (multi_hot != 0)  begin n_fail++; $display("FAIL proto_multi_hot: got %0d want 0", multi_hot); end
        $display("protocol: overlap %0d multi-hot %0d", ld_overlap, multi_hot);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = {32'hC0DEBEEF, 32'h12345678, 32'hA5A50F01, 32'h009E6D55};
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_in_shift();
        test_withdraw();
        test_req_at_done();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
